fifo_read_downsizer: RTL and testbench
======================================

Name: fifo_read_downsizer

Overview:
- Read-side stage that drains the async FIFO in the read clock domain.
- Pops wide words from the FIFO's show-ahead read port and splits each word into IN_WIDTH/OUT_WIDTH narrow beats, least-significant beat first.
- Presents the beats on a valid/ready stream toward the consumer logic.
- Sustains one beat per cycle across word boundaries while the FIFO is non-empty and the consumer is ready.

Parameters:
- IN_WIDTH, 512, FIFO word width. Must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 64, output beat width. RATIO = IN_WIDTH/OUT_WIDTH must be at least 2.
- CNT_WIDTH, 3, beat counter width. Must satisfy 2^CNT_WIDTH >= RATIO.

Ports:
- read_clk  in  1  Read-domain clock.
- read_rst_n  in  1  Asynchronous, active-low reset. The block has one clock (read_clk). The reset is asynchronous and active-low.
- fifo_empty  in  1  FIFO has no readable word.
- fifo_data  in  IN_WIDTH  FIFO head word. Valid combinationally whenever fifo_empty=0 (show-ahead).
- fifo_rd_en  out  1  Pop request. Advances the FIFO read pointer at the read_clk edge.
- m_valid  out  1  Beat available.
- m_ready  in  1  Consumer accepts the beat.
- m_data  out  OUT_WIDTH  Current beat.
- m_last  out  1  Marks the final beat of a word.
- words_out  out  16  Count of fully emitted words. Wraps modulo 2^16.

Behaviour:
- State:
  - word_reg[IN_WIDTH]
  - word_valid (1 bit)
  - beat_cnt[CNT_WIDTH]
  - words_out counter
- Reset (async assert, sync-safe deassert by the system):
  - word_valid=0, beat_cnt=0, word_reg=0, words_out=0.
  - Outputs: m_valid=0, m_data=0, m_last=0, fifo_rd_en=0.
- Handshake:
  - Beat transfer = m_valid & m_ready at a rising read_clk.
  - Once m_valid=1, m_valid and m_data hold stable until transfer.
- Derived signals:
  - last_beat = (beat_cnt == RATIO-1).
  - take = m_valid & m_ready & last_beat.
- fifo_rd_en (combinational) = ~fifo_empty & (~word_valid | take).
  - Never asserted while fifo_empty=1.
  - Never asserted while in reset.
- Outputs:
  - m_valid = word_valid.
  - m_data = word_reg[beat_cnt*OUT_WIDTH +: OUT_WIDTH].
  - m_last = word_valid & last_beat.
- Sequential update:
  - fifo_rd_en=1: word_reg<=fifo_data, word_valid<=1, beat_cnt<=0.
  - Else if take: word_valid<=0, beat_cnt<=0.
  - Else if transfer: beat_cnt<=beat_cnt+1.
  - take: words_out<=words_out+1, regardless of reload.
- Latency: FIFO word at head with word_valid=0 gives m_valid=1 on the next read_clk edge, i.e. 1 cycle.
- Throughput: with fifo_empty=0 and m_ready=1 held, m_valid stays 1 with no bubble between words. The last-beat transfer and the pop of the next word occur on the same edge.
- Backpressure: m_ready=0 freezes beat_cnt and word_reg, and holds fifo_rd_en=0 while word_valid=1.
- FIFO empty at the word boundary: after the last beat, m_valid drops to 0 until the FIFO is non-empty again. fifo_rd_en then pops at the next edge.
- FIFO emptying mid-word: no effect. The current word completes from word_reg.
- Reset mid-word: the partial word is discarded. No further beats are emitted from it. The FIFO pointer is not rewound, and resetting the FIFO is the system's responsibility.
- beat_cnt never exceeds RATIO-1. Non-power-of-two RATIO is legal. beat_cnt wraps to 0 only via take or reload.

Test Plan (bench uses IN_WIDTH=32, OUT_WIDTH=8, CNT_WIDTH=2):
- Reset check: hold read_rst_n=0 with fifo_empty=0 → fifo_rd_en=0, m_valid=0, words_out=0.
- Single word: fifo_data=0xDDCCBBAA pushed once, m_ready=1 → fifo_rd_en pulses 1 cycle. m_data sequence is AA, BB, CC, DD on 4 consecutive cycles, with m_last=1 only on DD. words_out=1. m_valid=0 afterwards.
- Back-to-back: 3 words 0x03020100, 0x07060504, 0x0B0A0908 queued, m_ready=1 → 12 consecutive beats 0x00..0x0B with no gap. m_last on beats 3, 7 and 11. fifo_rd_en is high on the same cycles as beats 3 and 7. words_out=3.
- Backpressure: m_ready toggles 1,0,0,1,1,0,1 during one word → beats appear in order with no duplicates or drops. m_data is stable while m_ready=0. No pop until DD transfers.
- Mid-word reset: assert read_rst_n=0 asynchronously after beat BB → m_valid falls immediately. After release with the FIFO empty, no beats appear. The next pushed word 0x44332211 streams 11, 22, 33, 44.
- Counter wrap: force 65536 words → words_out returns to 0x0000 and then increments normally.

Source files
------------

// File: rtl/fifo_read_downsizer.sv
// Read-side downsizer for the async FIFO. Pops wide words from the
// show-ahead read port and streams them out as narrow beats, least
// significant beat first, keeping one beat per cycle across word boundaries.
module fifo_read_downsizer #(
  parameter int IN_WIDTH  = 512,
  parameter int OUT_WIDTH = 64,
  parameter int CNT_WIDTH = 3
) (
  input  logic                 read_clk,
  input  logic                 read_rst_n,
  input  logic                 fifo_empty,
  input  logic [IN_WIDTH-1:0]  fifo_data,
  output logic                 fifo_rd_en,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OUT_WIDTH-1:0] m_data,
  output logic                 m_last,
  output logic [15:0]          words_out
);

  // IN_WIDTH must be a multiple of OUT_WIDTH with RATIO >= 2, and
  // CNT_WIDTH must be wide enough to count 0..RATIO-1.
  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(RATIO - 1);

  // Handshake: a beat moves when m_valid & m_ready are both high at a rising
  // read_clk. Once m_valid rises, m_valid and m_data hold until that
  // transfer. fifo_rd_en pops the FIFO head at the same edge it is high.

  logic [IN_WIDTH-1:0]  word_reg;
  logic                 word_valid;
  logic [CNT_WIDTH-1:0] beat_cnt;
  logic [15:0]          words_out_q;

  logic last_beat;
  logic transfer;
  logic take;

  // Beat position decode, handshake qualifiers and pop request. The pop is
  // gated by reset so nothing leaves the FIFO while the block is held idle.
  always_comb begin
    last_beat  = (beat_cnt == LAST_CNT);
    transfer   = word_valid & m_ready;
    take       = transfer & last_beat;
    fifo_rd_en = read_rst_n & ~fifo_empty & (~word_valid | take);
  end

  assign m_valid   = word_valid;
  assign m_data    = word_reg[int'(beat_cnt) * OUT_WIDTH +: OUT_WIDTH];
  assign m_last    = word_valid & last_beat;
  assign words_out = words_out_q;

  // Word holding register and beat pointer: reload on pop, retire on the
  // final beat, otherwise advance one beat per transfer.
  always_ff @(posedge read_clk or negedge read_rst_n) begin
    if (!read_rst_n) begin
      word_reg   <= '0;
      word_valid <= 1'b0;
      beat_cnt   <= '0;
    end else if (fifo_rd_en) begin
      word_reg   <= fifo_data;
      word_valid <= 1'b1;
      beat_cnt   <= '0;
    end else if (take) begin
      word_valid <= 1'b0;
      beat_cnt   <= '0;
    end else if (transfer) begin
      beat_cnt   <= beat_cnt + 1'b1;
    end
  end

  // Completed-word counter; counts every final beat whether or not a new
  // word is loaded on the same edge, and wraps naturally at 16 bits.
  always_ff @(posedge read_clk or negedge read_rst_n) begin
    if (!read_rst_n) begin
      words_out_q <= '0;
    end else if (take) begin
      words_out_q <= words_out_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_read_downsizer.sv
// Bench for fifo_read_downsizer with 32-bit words split into 8-bit beats.
// A queue models the show-ahead FIFO; pushed words are expanded into an
// expected beat queue that the output stream is scored against.
module tb_fifo_read_downsizer;

  localparam int IN_W  = 32;
  localparam int OUT_W = 8;
  localparam int CNT_W = 2;

  // ---------------- clock / reset ----------------
  logic             read_clk = 1'b0;
  logic             read_rst_n;
  logic             fifo_empty;
  logic [IN_W-1:0]  fifo_data;
  logic             fifo_rd_en;
  logic             m_valid;
  logic             m_ready;
  logic [OUT_W-1:0] m_data;
  logic             m_last;
  logic [15:0]      words_out;

  always #5 read_clk = ~read_clk;

  fifo_read_downsizer #(
    .IN_WIDTH (IN_W),
    .OUT_WIDTH(OUT_W),
    .CNT_WIDTH(CNT_W)
  ) dut (
    .read_clk  (read_clk),
    .read_rst_n(read_rst_n),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd_en(fifo_rd_en),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .words_out (words_out)
  );

  // ---------------- model state / scoreboard ----------------
  logic [IN_W-1:0] fifo_q[$];
  logic [8:0]      exp_q[$];   // {last, beat}
  logic [15:0]     exp_words;
  int              chk_n;
  int              err_n;

  // Per-cycle samples for directed checks
  logic s_valid;
  logic s_pop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_n++;
    assert (obs === exp) else begin
      err_n++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  endtask

  task automatic push(input logic [IN_W-1:0] w);
    fifo_q.push_back(w);
    for (int i = 0; i < IN_W / OUT_W; i++)
      exp_q.push_back({(i == IN_W / OUT_W - 1), w[i*OUT_W +: OUT_W]});
    drive_fifo();
  endtask

  // One clock cycle, starting and ending at a falling edge.
  task automatic cycle(input logic rdy);
    logic pop;
    m_ready = rdy;
    #1;
    s_valid = m_valid;
    s_pop   = fifo_rd_en;
    pop     = fifo_rd_en;
    check("rd_en_while_empty", 32'(fifo_rd_en & fifo_empty), 32'd0);
    if (m_valid) begin
      chk_n++;
      assert (exp_q.size() != 0) else begin
        err_n++;
        $error("FAIL spurious_beat: observed data 0x%0h expected no beat", m_data);
      end
      if (exp_q.size() != 0) begin
        check("m_data", 32'(m_data), 32'(exp_q[0][7:0]));
        check("m_last", 32'(m_last), 32'(exp_q[0][8]));
        if (m_ready) begin
          if (exp_q[0][8]) exp_words = exp_words + 16'd1;
          void'(exp_q.pop_front());
        end
      end
    end else begin
      check("m_last_idle", 32'(m_last), 32'd0);
    end
    @(posedge read_clk);
    #1;
    if (pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
    drive_fifo();
    @(negedge read_clk);
    check("words_out", 32'(words_out), 32'(exp_words));
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cycle(1'b1);
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    chk_n      = 0;
    err_n      = 0;
    exp_words  = '0;
    read_rst_n = 1'b0;
    m_ready    = 1'b0;
    fifo_empty = 1'b0;
    fifo_data  = 32'hDEADBEEF;

    // Reset holds everything idle even with the FIFO non-empty
    @(negedge read_clk);
    @(negedge read_clk);
    #1;
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_words_out", 32'(words_out), 32'd0);
    drive_fifo();
    @(negedge read_clk);
    read_rst_n = 1'b1;

    // Single word: one pop, 1-cycle latency, four beats, then idle
    push(32'hDDCCBBAA);
    cycle(1'b1);
    check("single_pop", 32'(s_pop), 32'd1);
    check("single_latency_valid0", 32'(s_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1);
      check("single_valid", 32'(s_valid), 32'd1);
      check("single_no_pop", 32'(s_pop), 32'd0);
    end
    cycle(1'b1);
    check("single_after_valid", 32'(s_valid), 32'd0);
    check("single_words", 32'(words_out), 32'd1);

    // Back-to-back: 12 beats with no bubble, pops on beats 3 and 7
    push(32'h03020100);
    push(32'h07060504);
    push(32'h0B0A0908);
    cycle(1'b1);
    check("b2b_first_pop", 32'(s_pop), 32'd1);
    for (int k = 0; k < 12; k++) begin
      cycle(1'b1);
      check("b2b_valid", 32'(s_valid), 32'd1);
      check("b2b_pop", 32'(s_pop), 32'((k == 3) || (k == 7)));
    end
    check("b2b_words", 32'(words_out), 32'd4);
    check("b2b_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: ready pattern 1,0,0,1,1,0,1; next word waits for DD
    begin
      logic [6:0] pat;
      pat = 7'b1011001;   // bit k = ready at step k
      push(32'hDDCCBBAA);
      cycle(1'b0);
      check("bp_load_pop", 32'(s_pop), 32'd1);
      push(32'h0F0E0D0C);
      for (int k = 0; k < 7; k++) begin
        cycle(pat[k]);
        check("bp_valid", 32'(s_valid), 32'd1);
        check("bp_pop", 32'(s_pop), 32'(k == 6));
      end
      drain("bp_drain", 8);
    end

    // Mid-word reset after beat BB discards the rest of the word
    push(32'hDDCCBBAA);
    cycle(1'b1);
    cycle(1'b1);
    cycle(1'b1);
    #3;
    read_rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(m_valid), 32'd0);
    check("midrst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("midrst_words", 32'(words_out), 32'd0);
    exp_q.delete();
    exp_words = '0;
    @(negedge read_clk);
    read_rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1);
      check("midrst_quiet", 32'(s_valid), 32'd0);
    end
    push(32'h44332211);
    cycle(1'b1);
    drain("midrst_next_word", 6);
    check("midrst_words_after", 32'(words_out), 32'd1);

    // Randomized traffic: random pushes, random consumer readiness
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 2) == 0 && fifo_q.size() < 4) push($urandom());
      cycle(1'($urandom_range(0, 1)));
    end
    drain("rand_drain", 100);
    check("rand_fifo_empty", 32'(fifo_q.size()), 32'd0);

    // Counter wrap: preload near the top, then stream three words
    force dut.words_out_q = 16'hFFFE;
    #1;
    release dut.words_out_q;
    exp_words = 16'hFFFE;
    #1;
    check("wrap_preload", 32'(words_out), 32'h0000FFFE);
    push($urandom());
    push($urandom());
    push($urandom());
    cycle(1'b1);
    drain("wrap_drain", 20);
    check("wrap_value", 32'(words_out), 32'h00000001);

    $display("Simulation finished: %0d checks, %0d errors", chk_n, err_n);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    err_n++;
    $display("FAIL timeout: observed no completion expected finish before limit");
    $display("Simulation finished: %0d checks, %0d errors", chk_n, err_n);
    $finish;
  end

endmodule
